tone_scan_ctrl: RTL and testbench

TONE_SCAN_CTRL -- requirements
Module: tone_scan_ctrl

---
 rtl/tone_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tone_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_scan_ctrl.sv
// Sequencer for a shared Goertzel core: steps every bin for each accepted sample,
// runs the final power pass at block end, then picks the strongest bin above threshold.
module tone_scan_ctrl #(
    parameter int DATA_WIDTH_IN  = 16,
    parameter int DATA_WIDTH_OUT = 8,
    parameter int NUM_BINS       = 8,
    parameter int BLOCK_LEN      = 205,
    parameter int PWR_WIDTH      = 32,
    parameter int BW             = $clog2(NUM_BINS)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    input  logic signed [DATA_WIDTH_IN-1:0]  i_data,
    input  logic [PWR_WIDTH-1:0]             i_threshold,
    output logic                             o_core_step,
    output logic                             o_core_final,
    output logic                             o_core_clear,
    output logic [BW-1:0]                    o_core_bin,
    output logic signed [DATA_WIDTH_IN-1:0]  o_core_data,
    input  logic                             i_pwr_valid,
    input  logic [PWR_WIDTH-1:0]             i_pwr,
    output logic                             o_valid,
    output logic [DATA_WIDTH_OUT-1:0]        o_data,
    output logic                             o_overrun
);

    localparam int CW = $clog2(BLOCK_LEN + 1);
    localparam logic [BW-1:0] LAST_BIN  = BW'(NUM_BINS - 1);
    localparam logic [CW-1:0] LAST_SAMP = CW'(BLOCK_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STEP    = 3'd1,
        S_FINAL   = 3'd2,
        S_COLLECT = 3'd3,
        S_DECIDE  = 3'd4,
        S_CLEAR   = 3'd5
    } state_t;

    state_t                           state_q;
    logic [BW-1:0]                    bin_q;
    logic [BW-1:0]                    res_cnt_q;
    logic [CW-1:0]                    samp_cnt_q;
    logic [PWR_WIDTH-1:0]             max_pwr_q;
    logic [BW-1:0]                    max_bin_q;
    logic signed [DATA_WIDTH_IN-1:0]  data_q;
    logic                             step_q;
    logic                             final_q;
    logic                             clear_q;
    logic                             valid_q;
    logic [DATA_WIDTH_OUT-1:0]        odata_q;
    logic                             overrun_q;

    logic [PWR_WIDTH-1:0]             max_pwr_d;
    logic [BW-1:0]                    max_bin_d;
    logic [DATA_WIDTH_OUT-1:0]        detect_d;

    // Running maximum including the current result; strict compare keeps the lower bin on ties.
    always_comb begin
        max_pwr_d = max_pwr_q;
        max_bin_d = max_bin_q;
        detect_d  = {DATA_WIDTH_OUT{1'b0}};
        if (i_pwr > max_pwr_q) begin
            max_pwr_d = i_pwr;
            max_bin_d = res_cnt_q;
        end else begin
            max_pwr_d = max_pwr_q;
        end
        if (max_pwr_d > i_threshold) begin
            detect_d = DATA_WIDTH_OUT'(max_bin_d) + DATA_WIDTH_OUT'(1);
        end else begin
            detect_d = {DATA_WIDTH_OUT{1'b0}};
        end
    end

    // Control FSM with all core strobes and results registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            bin_q      <= {BW{1'b0}};
            res_cnt_q  <= {BW{1'b0}};
            samp_cnt_q <= {CW{1'b0}};
            max_pwr_q  <= {PWR_WIDTH{1'b0}};
            max_bin_q  <= {BW{1'b0}};
            data_q     <= {DATA_WIDTH_IN{1'b0}};
            step_q     <= 1'b0;
            final_q    <= 1'b0;
            clear_q    <= 1'b0;
            valid_q    <= 1'b0;
            odata_q    <= {DATA_WIDTH_OUT{1'b0}};
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= i_valid && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        data_q  <= i_data;
                        bin_q   <= {BW{1'b0}};
                        step_q  <= 1'b1;
                        state_q <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (bin_q == LAST_BIN) begin
                        step_q     <= 1'b0;
                        bin_q      <= {BW{1'b0}};
                        samp_cnt_q <= samp_cnt_q + CW'(1);
                        if (samp_cnt_q == LAST_SAMP) begin
                            final_q <= 1'b1;
                            state_q <= S_FINAL;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        bin_q <= bin_q + BW'(1);
                    end
                end
                S_FINAL: begin
                    if (bin_q == LAST_BIN) begin
                        final_q   <= 1'b0;
                        bin_q     <= {BW{1'b0}};
                        res_cnt_q <= {BW{1'b0}};
                        state_q   <= S_COLLECT;
                    end else begin
                        bin_q <= bin_q + BW'(1);
                    end
                end
                S_COLLECT: begin
                    if (i_pwr_valid) begin
                        max_pwr_q <= max_pwr_d;
                        max_bin_q <= max_bin_d;
                        res_cnt_q <= res_cnt_q + BW'(1);
                        // Decision is registered on entry so the strobe is visible during DECIDE.
                        if (res_cnt_q == LAST_BIN) begin
                            valid_q <= 1'b1;
                            odata_q <= detect_d;
                            state_q <= S_DECIDE;
                        end
                    end
                end
                S_DECIDE: begin
                    valid_q <= 1'b0;
                    clear_q <= 1'b1;
                    state_q <= S_CLEAR;
                end
                S_CLEAR: begin
                    clear_q    <= 1'b0;
                    samp_cnt_q <= {CW{1'b0}};
                    res_cnt_q  <= {BW{1'b0}};
                    max_pwr_q  <= {PWR_WIDTH{1'b0}};
                    max_bin_q  <= {BW{1'b0}};
                    state_q    <= S_IDLE;
                end
                default: begin
                    step_q  <= 1'b0;
                    final_q <= 1'b0;
                    clear_q <= 1'b0;
                    valid_q <= 1'b0;
                    bin_q   <= {BW{1'b0}};
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_core_step  = step_q;
    assign o_core_final = final_q;
    assign o_core_clear = clear_q;
    assign o_core_bin   = bin_q;
    assign o_core_data  = data_q;
    assign o_valid      = valid_q;
    assign o_data       = odata_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_tone_scan_ctrl.sv
// Directed bench for tone_scan_ctrl with 4 bins and 8-sample blocks.
module tb_tone_scan_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               valid = 1'b0;
    logic signed [15:0] data = 16'sd0;
    logic [31:0]        thr = 32'd100;
    logic               pwr_valid = 1'b0;
    logic [31:0]        pwr = 32'd0;
    logic               core_step, core_final, core_clear, o_valid, o_overrun;
    logic [1:0]         core_bin;
    logic signed [15:0] core_data;
    logic [7:0]         o_data;

    int checks = 0;
    int errors = 0;
    int n_step = 0, n_final = 0, n_clear = 0, n_valid = 0, n_ovr = 0, n_excl = 0;

    tone_scan_ctrl #(
        .DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(8), .NUM_BINS(4), .BLOCK_LEN(8), .PWR_WIDTH(32)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_threshold(thr),
        .o_core_step(core_step), .o_core_final(core_final), .o_core_clear(core_clear),
        .o_core_bin(core_bin), .o_core_data(core_data), .i_pwr_valid(pwr_valid), .i_pwr(pwr),
        .o_valid(o_valid), .o_data(o_data), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters and strobe exclusivity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (core_step === 1'b1) n_step <= n_step + 1;
        if (core_final === 1'b1) n_final <= n_final + 1;
        if (core_clear === 1'b1) n_clear <= n_clear + 1;
        if (o_valid === 1'b1) n_valid <= n_valid + 1;
        if (o_overrun === 1'b1) n_ovr <= n_ovr + 1;
        if ((int'(core_step) + int'(core_final) + int'(core_clear)) > 1 ||
            (!core_step && !core_final && !core_clear && core_bin !== 2'd0))
            n_excl <= n_excl + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({core_step, core_final, core_clear, core_bin, core_data, o_valid, o_data, o_overrun} !== 30'd0) begin
            errors++;
            $display("FAIL %s: step=%b final=%b clear=%b bin=%0d data=%0d valid=%b odata=%0d ovr=%b, all must be 0",
                     name, core_step, core_final, core_clear, core_bin, core_data, o_valid, o_data, o_overrun);
        end
    endtask

    task automatic feed(input logic signed [15:0] v, input bit junk);
        valid = 1'b1;
        data  = v;
        tick();
        valid = 1'b0;
        data  = ~v;
        if (junk) begin
            pwr_valid = 1'b1;
            pwr       = 32'hFFFF_FFFF;
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (core_step !== 1'b1 || core_bin !== 2'(b) || core_data !== v || core_final !== 1'b0) begin
                errors++;
                $display("FAIL step: step=%b bin=%0d data=%0d, need step=1 bin=%0d data=%0d", core_step, core_bin, core_data, b, v);
            end
            tick();
        end
        pwr_valid = 1'b0;
    endtask

    task automatic finals();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (core_final !== 1'b1 || core_bin !== 2'(b) || core_step !== 1'b0) begin
                errors++;
                $display("FAIL final: final=%b bin=%0d step=%b, need final=1 bin=%0d", core_final, core_bin, core_step, b);
            end
            tick();
        end
        checks++;
        if (core_final !== 1'b0 || core_bin !== 2'd0) begin
            errors++;
            $display("FAIL final_end: final=%b bin=%0d, need 0 0", core_final, core_bin);
        end
    endtask

    task automatic powers(input logic [31:0] p [4], input logic [31:0] t, input logic [7:0] exp);
        thr = t;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL early_valid: o_valid=%b before result %0d, need 0", o_valid, i);
            end
            pwr_valid = 1'b1;
            pwr       = p[i];
            tick();
        end
        pwr_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_data !== exp || core_clear !== 1'b0) begin
            errors++;
            $display("FAIL decide: valid=%b data=%0d clear=%b, need 1 %0d 0", o_valid, o_data, core_clear, exp);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || core_clear !== 1'b1 || o_data !== exp) begin
            errors++;
            $display("FAIL clear: valid=%b clear=%b data=%0d, need 0 1 %0d", o_valid, core_clear, o_data, exp);
        end
        tick();
        checks++;
        if (core_clear !== 1'b0 || o_data !== exp) begin
            errors++;
            $display("FAIL hold: clear=%b data=%0d, need 0 %0d", core_clear, o_data, exp);
        end
    endtask

    task automatic run_block(input logic signed [15:0] base, input bit junk, input logic [31:0] p [4],
                             input logic [31:0] t, input logic [7:0] exp);
        int s0, f0, v0;
        s0 = n_step; f0 = n_final; v0 = n_valid;
        for (int i = 0; i < 8; i++) begin
            feed(base + 16'(i * 37), junk);
            if (i < 7) tick();
        end
        finals();
        tick();
        checks++;
        if (n_step - s0 != 32 || n_final - f0 != 4 || n_valid != v0) begin
            errors++;
            $display("FAIL pulse_count: steps=%0d finals=%0d valids=%0d, need 32 4 0", n_step - s0, n_final - f0, n_valid - v0);
        end
        powers(p, t, exp);
        checks++;
        if (n_valid - v0 != 1) begin
            errors++;
            $display("FAIL valid_count: %0d, need 1", n_valid - v0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("after_reset");
    endtask

    task automatic test_detect();
        int c0;
        c0 = n_clear;
        run_block(-16'sd100, 1'b0, '{32'd10, 32'd500, 32'd200, 32'd499}, 32'd100, 8'd2);
        checks++;
        if (n_clear - c0 != 1) begin
            errors++;
            $display("FAIL clear_count: %0d, need 1", n_clear - c0);
        end
    endtask

    task automatic test_tie_and_threshold();
        run_block(16'sd1234, 1'b0, '{32'd300, 32'd300, 32'd50, 32'd50}, 32'd100, 8'd1);
        run_block(16'sd7, 1'b0, '{32'd100, 32'd100, 32'd100, 32'd100}, 32'd100, 8'd0);
    endtask

    task automatic test_overrun();
        int o0;
        o0 = n_ovr;
        tick();
        valid = 1'b1;
        data  = 16'sd555;
        tick();
        data = -16'sd9;
        tick();
        valid = 1'b0;
        checks++;
        if (o_overrun !== 1'b1 || core_data !== 16'sd555 || core_bin !== 2'd1) begin
            errors++;
            $display("FAIL overrun: ovr=%b data=%0d bin=%0d, need 1 555 1", o_overrun, core_data, core_bin);
        end
        tick();
        checks++;
        if (o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pulse: ovr=%b, need 0", o_overrun);
        end
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            feed(16'sd20 + 16'(i), 1'b0);
        end
        finals();
        tick();
        powers('{32'd1, 32'd2, 32'd3, 32'd400}, 32'd100, 8'd4);
        checks++;
        if (n_ovr - o0 != 1) begin
            errors++;
            $display("FAIL overrun_count: %0d, need 1", n_ovr - o0);
        end
    endtask

    task automatic test_reset_midblock();
        int f0, c0;
        for (int i = 0; i < 5; i++) begin
            tick();
            feed(16'sd300 + 16'(i), 1'b0);
        end
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        check_all_zero("hold_reset");
        rst = 1'b0;
        tick();
        f0 = n_final;
        c0 = n_clear;
        for (int i = 0; i < 7; i++) begin
            tick();
            feed(-16'sd50 - 16'(i), 1'b0);
        end
        checks++;
        if (core_final !== 1'b0 || n_final != f0 || n_clear != c0) begin
            errors++;
            $display("FAIL reset_discard: final=%b finals=%0d clears=%0d, need 0 0 0", core_final, n_final - f0, n_clear - c0);
        end
        tick();
        feed(-16'sd77, 1'b0);
        finals();
        tick();
        powers('{32'd900, 32'd5, 32'd5, 32'd5}, 32'd100, 8'd1);
    endtask

    task automatic test_pwr_ignored();
        run_block(16'sd42, 1'b1, '{32'd10, 32'd500, 32'd200, 32'd499}, 32'd100, 8'd2);
    endtask

    initial begin
        test_reset();
        test_detect();
        test_tie_and_threshold();
        test_overrun();
        test_reset_midblock();
        test_pwr_ignored();
        tick();
        checks++;
        if (n_excl != 0) begin
            errors++;
            $display("FAIL exclusive: %0d bad cycles, need 0", n_excl);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
